// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome encoding and the entry recorded
// for each outstanding predicted conditional branch.
package mips_core_pkg;

    // Width of PCs held in the branch queue; top-level ports are cast to it.
    localparam int BQ_ADDR_WIDTH = 32;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef struct packed {
        logic [BQ_ADDR_WIDTH-1:0] pc;
        BranchOutcome             prediction;
        logic [BQ_ADDR_WIDTH-1:0] recovery_target;
    } branch_queue_entry_t;

endpackage

// File: rtl/branch_fifo.sv
// Synchronous in-order FIFO of predicted branches. Flush empties the queue
// and wins over a same-cycle push or pop. A push is refused when full even
// if a pop happens in the same cycle.
module branch_fifo
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  branch_queue_entry_t         push_entry,
    input  logic                        pop,
    input  logic                        flush,
    output branch_queue_entry_t         head_entry,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int PTR_W = $clog2(DEPTH);

    branch_queue_entry_t mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count_q;
    logic                do_push;
    logic                do_pop;

    assign full       = (count_q == (PTR_W+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign head_entry = mem[head];
    assign do_push    = push & ~full & ~flush;
    assign do_pop     = pop & ~empty & ~flush;

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are meaningless while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= push_entry;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: matches each EX resolve against the
// oldest recorded prediction, emits registered predictor feedback, a
// one-cycle redirect on mispredict, and saturating statistics counters.
module branch_resolve_unit
    import mips_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push_valid,
    input  logic [ADDR_WIDTH-1:0] i_push_pc,
    input  logic                  i_push_prediction,
    input  logic [ADDR_WIDTH-1:0] i_push_recovery_target,
    output logic                  o_push_ready,
    input  logic                  i_res_valid,
    input  logic                  i_res_outcome,
    output logic                  o_fb_valid,
    output logic [ADDR_WIDTH-1:0] o_fb_pc,
    output logic                  o_fb_prediction,
    output logic                  o_fb_outcome,
    output logic                  o_redirect_valid,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic [CNT_WIDTH-1:0]  o_branch_count,
    output logic [CNT_WIDTH-1:0]  o_mispredict_count,
    output logic                  o_underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    branch_queue_entry_t   push_entry;
    branch_queue_entry_t   head_entry;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PTR_W:0]        fifo_count;
    logic                  res_fire_p0;
    logic                  mispredict_p0;

    logic                  fb_valid_p1;
    logic [ADDR_WIDTH-1:0] fb_pc_p1;
    logic                  fb_prediction_p1;
    logic                  fb_outcome_p1;
    logic                  redirect_valid_p1;
    logic [ADDR_WIDTH-1:0] redirect_pc_p1;
    logic [CNT_WIDTH-1:0]  branch_count_p1;
    logic [CNT_WIDTH-1:0]  mispredict_count_p1;
    logic                  underflow_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign push_entry.pc              = BQ_ADDR_WIDTH'(i_push_pc);
    assign push_entry.prediction      = BranchOutcome'(i_push_prediction);
    assign push_entry.recovery_target = BQ_ADDR_WIDTH'(i_push_recovery_target);

    // Stage p0: resolve decision against the head entry, purely from state + i_res_*.
    assign res_fire_p0   = i_res_valid & (fifo_count != '0);
    assign mispredict_p0 = res_fire_p0 & (logic'(head_entry.prediction) != i_res_outcome);
    assign o_push_ready  = ~fifo_full;

    branch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (i_push_valid),
        .push_entry (push_entry),
        .pop        (res_fire_p0),
        .flush      (mispredict_p0),
        .head_entry (head_entry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Stage p1: predictor feedback, data fields hold between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_valid_p1      <= 1'b0;
            fb_pc_p1         <= '0;
            fb_prediction_p1 <= 1'b0;
            fb_outcome_p1    <= 1'b0;
        end else begin
            fb_valid_p1 <= res_fire_p0;
            if (res_fire_p0) begin
                fb_pc_p1         <= ADDR_WIDTH'(head_entry.pc);
                fb_prediction_p1 <= logic'(head_entry.prediction);
                fb_outcome_p1    <= i_res_outcome;
            end
        end
    end

    // Stage p1: one-cycle redirect pulse; target holds after the pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid_p1 <= 1'b0;
            redirect_pc_p1    <= '0;
        end else begin
            redirect_valid_p1 <= mispredict_p0;
            if (mispredict_p0) redirect_pc_p1 <= ADDR_WIDTH'(head_entry.recovery_target);
        end
    end

    // Stage p1: saturating statistics and the sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_p1     <= '0;
            mispredict_count_p1 <= '0;
            underflow_p1        <= 1'b0;
        end else begin
            if (res_fire_p0)                branch_count_p1     <= sat_inc(branch_count_p1);
            if (mispredict_p0)              mispredict_count_p1 <= sat_inc(mispredict_count_p1);
            if (i_res_valid && fifo_empty)  underflow_p1        <= 1'b1;
        end
    end

    assign o_fb_valid         = fb_valid_p1;
    assign o_fb_pc            = fb_pc_p1;
    assign o_fb_prediction    = fb_prediction_p1;
    assign o_fb_outcome       = fb_outcome_p1;
    assign o_redirect_valid   = redirect_valid_p1;
    assign o_redirect_pc      = redirect_pc_p1;
    assign o_branch_count     = branch_count_p1;
    assign o_mispredict_count = mispredict_count_p1;
    assign o_underflow        = underflow_p1;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: a queue model of outstanding branches
// produces expected feedback, which is scoreboarded against the DUT.
module tb_branch_resolve_unit;
    import mips_core_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_push_valid;
    logic [AW-1:0] i_push_pc;
    logic          i_push_prediction;
    logic [AW-1:0] i_push_recovery_target;
    logic          o_push_ready;
    logic          i_res_valid;
    logic          i_res_outcome;
    logic          o_fb_valid;
    logic [AW-1:0] o_fb_pc;
    logic          o_fb_prediction;
    logic          o_fb_outcome;
    logic          o_redirect_valid;
    logic [AW-1:0] o_redirect_pc;
    logic [CW-1:0] o_branch_count;
    logic [CW-1:0] o_mispredict_count;
    logic          o_underflow;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .i_push_valid           (i_push_valid),
        .i_push_pc              (i_push_pc),
        .i_push_prediction      (i_push_prediction),
        .i_push_recovery_target (i_push_recovery_target),
        .o_push_ready           (o_push_ready),
        .i_res_valid            (i_res_valid),
        .i_res_outcome          (i_res_outcome),
        .o_fb_valid             (o_fb_valid),
        .o_fb_pc                (o_fb_pc),
        .o_fb_prediction        (o_fb_prediction),
        .o_fb_outcome           (o_fb_outcome),
        .o_redirect_valid       (o_redirect_valid),
        .o_redirect_pc          (o_redirect_pc),
        .o_branch_count         (o_branch_count),
        .o_mispredict_count     (o_mispredict_count),
        .o_underflow            (o_underflow)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic          pred;
        logic [AW-1:0] rec;
    } ent_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic          pred;
        logic          outcome;
        logic          mis;
        logic [AW-1:0] rec;
    } exp_t;

    ent_t mq[$];
    exp_t exp_q[$];

    logic [CW-1:0] m_branch, m_mis;
    logic          m_underflow;
    logic [AW-1:0] m_fb_pc, m_rd_pc;
    logic          m_fb_pred, m_fb_out;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Compare every output against the model after an active edge.
    task automatic monitor();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_branch = (&m_branch) ? m_branch : m_branch + 1;
            if (e.mis) begin
                m_mis   = (&m_mis) ? m_mis : m_mis + 1;
                m_rd_pc = e.rec;
            end
            m_fb_pc   = e.pc;
            m_fb_pred = e.pred;
            m_fb_out  = e.outcome;
            check("fb_valid", o_fb_valid, 1);
            check("redirect_valid", o_redirect_valid, e.mis);
        end else begin
            check("fb_valid_idle", o_fb_valid, 0);
            check("redirect_valid_idle", o_redirect_valid, 0);
        end
        check("fb_pc", o_fb_pc, m_fb_pc);
        check("fb_prediction", o_fb_prediction, m_fb_pred);
        check("fb_outcome", o_fb_outcome, m_fb_out);
        check("redirect_pc", o_redirect_pc, m_rd_pc);
        check("branch_count", o_branch_count, m_branch);
        check("mispredict_count", o_mispredict_count, m_mis);
        check("underflow", o_underflow, m_underflow);
    endtask

    // One clock of stimulus: model the queue, then drive, clock and check.
    task automatic step(input logic pv, input logic [AW-1:0] pc, input logic pred,
                        input logic [AW-1:0] rec, input logic rv, input logic oc);
        ent_t h;
        ent_t n;
        exp_t e;
        logic push_ok;
        i_push_valid           = pv;
        i_push_pc              = pc;
        i_push_prediction      = pred;
        i_push_recovery_target = rec;
        i_res_valid            = rv;
        i_res_outcome          = oc;
        check("push_ready", o_push_ready, (mq.size() != DEPTH));
        push_ok = pv && (mq.size() != DEPTH);
        if (rv && mq.size() > 0) begin
            h         = mq.pop_front();
            e.pc      = h.pc;
            e.pred    = h.pred;
            e.outcome = oc;
            e.mis     = (h.pred != oc);
            e.rec     = h.rec;
            exp_q.push_back(e);
            if (e.mis) begin
                mq.delete();
                push_ok = 1'b0;
            end
        end else if (rv) begin
            m_underflow = 1'b1;
        end
        if (push_ok) begin
            n.pc   = pc;
            n.pred = pred;
            n.rec  = rec;
            mq.push_back(n);
        end
        @(posedge clk);
        #1;
        i_push_valid = 1'b0;
        i_res_valid  = 1'b0;
        monitor();
    endtask

    task automatic do_reset(input logic res_during);
        rst_n        = 1'b0;
        i_push_valid = 1'b1;
        i_push_pc    = 32'hDEAD_0000;
        i_res_valid  = res_during;
        i_res_outcome = 1'b0;
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        i_push_valid = 1'b0;
        i_res_valid  = 1'b0;
        mq.delete();
        exp_q.delete();
        m_branch    = '0;
        m_mis       = '0;
        m_underflow = 1'b0;
        m_fb_pc     = '0;
        m_rd_pc     = '0;
        m_fb_pred   = 1'b0;
        m_fb_out    = 1'b0;
        check("ready_after_reset", o_push_ready, 1);
        monitor();
    endtask

    initial begin
        rst_n                  = 1'b0;
        i_push_valid           = 1'b0;
        i_push_pc              = '0;
        i_push_prediction      = 1'b0;
        i_push_recovery_target = '0;
        i_res_valid            = 1'b0;
        i_res_outcome          = 1'b0;

        // 1: fill, refused fifth push, drain, underflow on fifth resolve
        do_reset(1'b0);
        for (int i = 0; i < 4; i++)
            step(1, 32'h100 + 32'(i) * 32'h10, 1, 32'h1000 + 32'(i), 0, 0);
        check("t1_full_ready", o_push_ready, 0);
        step(1, 32'h140, 1, 32'h1004, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 0, 1, 1);
        check("t1_underflow", o_underflow, 1);
        check("t1_last_fb_pc", o_fb_pc, 32'h130);

        // 2: correctly predicted not-taken branch
        do_reset(1'b0);
        step(1, 32'h200, 0, 32'h240, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check("t2_fb_pc", o_fb_pc, 32'h200);
        check("t2_redirect", o_redirect_valid, 0);
        check("t2_branch_count", o_branch_count, 1);
        check("t2_mis_count", o_mispredict_count, 0);

        // 3: mispredict flushes younger entries and a same-cycle push
        step(1, 32'h300, 1, 32'h308, 0, 0);
        step(1, 32'h310, 1, 32'h318, 0, 0);
        step(1, 32'h320, 1, 32'h328, 0, 0);
        step(1, 32'h330, 1, 32'h338, 1, 0);
        check("t3_redirect_pc", o_redirect_pc, 32'h308);
        check("t3_ready", o_push_ready, 1);
        step(0, 0, 0, 0, 1, 1);
        check("t3_underflow", o_underflow, 1);
        step(0, 0, 0, 0, 0, 0);

        // 4: full queue, correct resolve with a push: push refused
        do_reset(1'b0);
        for (int i = 0; i < 4; i++)
            step(1, 32'h500 + 32'(i) * 32'h10, 1, 32'h5000, 0, 0);
        step(1, 32'h540, 1, 32'h5000, 1, 1);
        check("t4_ready_back", o_push_ready, 1);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 1, 1);
        check("t4_underflow", o_underflow, 1);

        // 5: streaming resolves with overlapping pushes wrap the pointers
        do_reset(1'b0);
        step(1, 32'h600, 0, 32'h6000, 0, 0);
        for (int i = 1; i < 2 * DEPTH + 1; i++)
            step(1, 32'h600 + 32'(i) * 32'h10, logic'(i % 2), 32'h6000, 1, mq[0].pred);
        step(0, 0, 0, 0, 1, mq[0].pred);
        check("t5_branch_count", o_branch_count, 2 * DEPTH + 1);
        check("t5_fb_pc", o_fb_pc, 32'h680);

        // 6: reset with entries outstanding and a resolve pending
        step(1, 32'h700, 1, 32'h7000, 0, 0);
        step(1, 32'h710, 1, 32'h7000, 0, 0);
        step(1, 32'h720, 1, 32'h7000, 0, 0);
        do_reset(1'b1);
        check("t6_fb_pc_zero", o_fb_pc, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("t6_underflow_empty", o_underflow, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
